fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Parametrised fetch program-counter register for the superscalar front end, successor to the single-issue PC register. It holds the fetch-block PC, advances only when the pipeline is enabled and both caches report a hit, and selects the next PC by priority: redirect, then held redirect, then branch prediction, then sequential block. A redirect that arrives during a cache stall is captured and applied on the next advance, so it is never lost.

## Interface
- XLEN, 32: PC width in bits.
- FETCH_WIDTH, 2: instructions per fetch block. Must be a power of two, 1..8.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset. Asynchronous, active-low.
- en  in  1  pipeline advance enable from hazard unit.
- Ihit  in  1  instruction cache hit.
- Dhit  in  1  data cache hit.
- redirect_valid  in  1  branch/exception resolution redirect.
- redirect_pc  in  XLEN  redirect target.
- bp_taken  in  1  predictor says the current block ends in a taken branch.
- bp_target  in  XLEN  predicted target.
- pc  out  XLEN  current fetch PC, registered.
- lane_mask  out  FETCH_WIDTH  valid lanes of the current block. Bit i is 1 when i >= the word offset of pc within the block.
- redirect_pending  out  1  high while a captured redirect is waiting.

## Operation
- advance = en & Ihit & Dhit.
- Block size is B = 4*FETCH_WIDTH bytes. Sequential next PC is (pc & ~(B-1)) + B, wrapping modulo 2^XLEN.
- Bits [1:0] of redirect_pc and bp_target are forced to 0 before use.
- FSM has two states: RUN and HOLD. A held-target register hold_pc is valid only in HOLD.
- RUN, advance, redirect_valid: pc <= redirect_pc; stay in RUN.
- RUN, advance, no redirect: pc <= bp_target if bp_taken, else the sequential PC.
- RUN, !advance, redirect_valid: hold_pc <= redirect_pc; go to HOLD; pc is unchanged.
- RUN, !advance, no redirect: no change.
- HOLD, advance, redirect_valid: pc <= redirect_pc, because the newer redirect wins; go to RUN.
- HOLD, advance, no redirect: pc <= hold_pc; go to RUN. bp_taken is ignored in this cycle.
- HOLD, !advance, redirect_valid: hold_pc <= redirect_pc (overwrite); stay in HOLD.
- HOLD, !advance, no redirect: no change.
- redirect_pending = (state == HOLD).
- lane_mask is combinational from the registered pc. When FETCH_WIDTH = 1, lane_mask = 1'b1.

## Timing
- Reset: pc = RESET_VECTOR, state = RUN, hold_pc = 0, redirect_pending = 0, lane_mask taken from RESET_VECTOR.
- Asserting resetn low in the middle of a HOLD discards the held redirect immediately, without waiting for a clock edge.
- Latency: a selected next PC appears on pc one cycle after the advancing edge.
- A redirect captured while stalled shows redirect_pending = 1 from the next edge. It is applied at the first advancing edge.
- A stall of any length never drops the most recent redirect and never advances pc.

## Configuration
- FETCH_PC_BP_EN defined: bp_taken and bp_target take part in next-PC selection as described above.
- FETCH_PC_BP_EN undefined: the bp_taken and bp_target ports stay in the port list but are ignored. The next PC when not redirecting is always the sequential PC.

## Structure
- Shared package fetch_pkg holds:
  - typedef pc_t (logic [XLEN-1:0]);
  - the FSM enum fetch_pc_state_e {RUN, HOLD};
  - the function block_align(pc, FETCH_WIDTH).
- Sub-module fetch_lane_mask: combinational pc to lane_mask generator, parametrised by FETCH_WIDTH. It is reused by the decode-side alignment logic.

## Test plan
- Reset release with RESET_VECTOR = 32'h0, FETCH_WIDTH = 2, advance held high -> pc steps 0x0, 0x8, 0x10. lane_mask = 2'b11 on every block.
- Redirect to 0x104 with advance high -> next pc = 0x104, lane_mask = 2'b10. The following advance gives pc = 0x108.
- Ihit low for 3 cycles with redirect_valid pulsed at 0x200 on the first stall cycle -> pc unchanged and redirect_pending = 1 during the stall. On the first hit, pc = 0x200 and redirect_pending = 0.
- In HOLD with hold_pc = 0x200, a second redirect to 0x300 while still stalled -> after the advance, pc = 0x300.
- bp_taken with bp_target = 0x403 at pc 0x40 -> pc = 0x400 when FETCH_PC_BP_EN is defined, pc = 0x48 when it is undefined.
- resetn low mid-HOLD -> pc = RESET_VECTOR and redirect_pending = 0 asynchronously. After release, sequential fetch resumes from RESET_VECTOR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch front-end types and helpers: PC type, fetch-PC FSM states and
// fetch-block alignment.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] pc_t;

  // RUN: fetching normally. HOLD: a redirect arrived during a stall and waits.
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_pc_state_e;

  // Clear the byte offset inside a fetch block of 4*fetch_width bytes.
  function automatic pc_t block_align(input pc_t pc, input int unsigned fetch_width);
    pc_t mask;
    mask = pc_t'(4 * fetch_width - 1);
    return pc & ~mask;
  endfunction

endpackage

// File: rtl/fetch_lane_mask.sv
// Valid-lane mask for a fetch block: lane i is valid when it sits at or after
// the word offset of pc within the block. Shared with decode-side alignment.
module fetch_lane_mask #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned FETCH_WIDTH = 2
) (
  input  logic [XLEN-1:0]        pc,
  output logic [FETCH_WIDTH-1:0] lane_mask
);

  if (FETCH_WIDTH == 1) begin : g_single
    // A one-lane block is always fully valid.
    assign lane_mask = 1'b1;
    logic unused_pc;
    assign unused_pc = ^pc;
  end else begin : g_multi
    localparam int unsigned OFS_W = $clog2(FETCH_WIDTH);
    logic [OFS_W-1:0] word_ofs;
    assign word_ofs = pc[OFS_W+1:2];

    logic unused_pc;
    assign unused_pc = ^{pc[XLEN-1:OFS_W+2], pc[1:0]};

    // Lanes before the entry word belong to the previous flow and are masked.
    always_comb begin
      lane_mask = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        lane_mask[i] = (OFS_W'(i) >= word_ofs);
      end
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-block program counter. Advances on en & Ihit & Dhit; next PC priority
// is redirect, held redirect, branch prediction, sequential block. Redirects
// seen during a stall are parked in hold_q (state HOLD) until the next advance.
// Optional feature: define FETCH_PC_BP_EN to let bp_taken/bp_target steer the
// next PC; otherwise those ports are ignored.
//
// Handshake: there is no valid/ready pair here; redirect_valid is a one-cycle
// qualifier for redirect_pc and is always accepted (applied or parked) on the
// edge it is seen, so a source never needs to hold it.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     FETCH_WIDTH  = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic                   Ihit,
  input  logic                   Dhit,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   bp_taken,
  input  logic [XLEN-1:0]        bp_target,
  output logic [XLEN-1:0]        pc,
  output logic [FETCH_WIDTH-1:0] lane_mask,
  output logic                   redirect_pending
);

  if (!(FETCH_WIDTH inside {1, 2, 4, 8})) begin : g_bad_width
    $error("fetch_pc_unit: FETCH_WIDTH must be 1, 2, 4 or 8");
  end

  localparam int unsigned BLOCK_BYTES = 4 * FETCH_WIDTH;

  fetch_pc_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_q, hold_d;

  logic            advance;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] seq_base;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] pred_pc;

  assign advance   = en & Ihit & Dhit;
  assign redir_tgt = {redirect_pc[XLEN-1:2], 2'b00};

  // Alignment only touches the low few bits, so wider PCs mask inline.
  if (XLEN == $bits(pc_t)) begin : g_pkg_align
    assign seq_base = block_align(pc_q, FETCH_WIDTH);
  end else begin : g_wide_align
    assign seq_base = pc_q & ~(XLEN'(BLOCK_BYTES - 1));
  end
  assign seq_pc = seq_base + XLEN'(BLOCK_BYTES);

`ifdef FETCH_PC_BP_EN
  logic [XLEN-1:0] bp_tgt;
  logic            unused_low;
  assign bp_tgt     = {bp_target[XLEN-1:2], 2'b00};
  assign pred_pc    = bp_taken ? bp_tgt : seq_pc;
  assign unused_low = ^{redirect_pc[1:0], bp_target[1:0]};
`else
  logic unused_bp;
  assign pred_pc   = seq_pc;
  assign unused_bp = ^{bp_taken, bp_target, redirect_pc[1:0]};
`endif

  // Next-state and next-PC selection for the RUN/HOLD redirect tracker.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    unique case (state_q)
      RUN: begin
        if (advance) begin
          pc_d = redirect_valid ? redir_tgt : pred_pc;
        end else if (redirect_valid) begin
          hold_d  = redir_tgt;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          // A fresh redirect is newer than the parked one; prediction is
          // stale here because it was made for the pre-redirect flow.
          pc_d    = redirect_valid ? redir_tgt : hold_q;
          state_d = RUN;
        end else if (redirect_valid) begin
          hold_d = redir_tgt;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, PC and held-target registers; reset discards any parked redirect.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  assign pc               = pc_q;
  assign redirect_pending = (state_q == HOLD);

  fetch_lane_mask #(
    .XLEN       (XLEN),
    .FETCH_WIDTH(FETCH_WIDTH)
  ) u_lane_mask (
    .pc       (pc_q),
    .lane_mask(lane_mask)
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit (XLEN 32, FETCH_WIDTH 2, reset vector 0).
module tb_fetch_pc_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FW   = 2;

  logic            clk;
  logic            resetn;
  logic            en;
  logic            Ihit;
  logic            Dhit;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            bp_taken;
  logic [XLEN-1:0] bp_target;
  logic [XLEN-1:0] pc;
  logic [FW-1:0]   lane_mask;
  logic            redirect_pending;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pc_unit #(
    .XLEN        (XLEN),
    .FETCH_WIDTH (FW),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .en              (en),
    .Ihit            (Ihit),
    .Dhit            (Dhit),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .bp_taken        (bp_taken),
    .bp_target       (bp_target),
    .pc              (pc),
    .lane_mask       (lane_mask),
    .redirect_pending(redirect_pending)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs set before this call are sampled at the edge, outputs
  // are looked at 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [XLEN-1:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
  endtask

  task automatic no_redirect();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  initial begin
    logic [XLEN-1:0] bp_exp;

    resetn = 1'b0;
    en = 1'b1; Ihit = 1'b1; Dhit = 1'b1;
    bp_taken = 1'b0; bp_target = '0;
    no_redirect();

    // Reset state, before any clock edge
    #2;
    check("rst_pc", pc, 32'h0);
    check("rst_pending", redirect_pending, 1'b0);
    check("rst_lane", lane_mask, 2'b11);

    step();
    resetn = 1'b1;
    check("rel_pc", pc, 32'h0);
    step();
    check("seq_pc1", pc, 32'h8);
    check("seq_lane1", lane_mask, 2'b11);
    step();
    check("seq_pc2", pc, 32'h10);
    check("seq_lane2", lane_mask, 2'b11);

    // Redirect into the middle of a block
    redirect(32'h104);
    step();
    check("redir_pc", pc, 32'h104);
    check("redir_lane", lane_mask, 2'b10);
    no_redirect();
    step();
    check("redir_next_pc", pc, 32'h108);
    check("redir_next_lane", lane_mask, 2'b11);

    // Three-cycle Ihit stall with a redirect on the first stall cycle
    Ihit = 1'b0;
    redirect(32'h200);
    step();
    check("stall1_pc", pc, 32'h108);
    check("stall1_pend", redirect_pending, 1'b1);
    no_redirect();
    step();
    check("stall2_pc", pc, 32'h108);
    check("stall2_pend", redirect_pending, 1'b1);
    step();
    check("stall3_pc", pc, 32'h108);
    check("stall3_pend", redirect_pending, 1'b1);
    Ihit = 1'b1;
    step();
    check("held_apply_pc", pc, 32'h200);
    check("held_apply_pend", redirect_pending, 1'b0);

    // Newer redirect overwrites the held one during the stall
    Ihit = 1'b0;
    redirect(32'h200);
    step();
    check("ovw_pend", redirect_pending, 1'b1);
    redirect(32'h300);
    step();
    check("ovw_pc_stalled", pc, 32'h200);
    check("ovw_pend2", redirect_pending, 1'b1);
    no_redirect();
    Ihit = 1'b1;
    step();
    check("ovw_apply_pc", pc, 32'h300);
    check("ovw_apply_pend", redirect_pending, 1'b0);

    // Held redirect beats a live prediction; low target bits are dropped
    Dhit = 1'b0;
    redirect(32'h503);
    step();
    check("dstall_pc", pc, 32'h300);
    check("dstall_pend", redirect_pending, 1'b1);
    no_redirect();
    Dhit = 1'b1;
    bp_taken = 1'b1;
    bp_target = 32'h700;
    step();
    check("hold_vs_bp_pc", pc, 32'h500);
    bp_taken = 1'b0;
    bp_target = '0;

    // en low stalls without a redirect: nothing changes
    en = 1'b0;
    step();
    check("en_stall_pc", pc, 32'h500);
    check("en_stall_pend", redirect_pending, 1'b0);
    en = 1'b1;

    // Branch prediction at pc 0x40
    redirect(32'h40);
    step();
    check("bp_setup_pc", pc, 32'h40);
    no_redirect();
    bp_taken = 1'b1;
    bp_target = 32'h403;
`ifdef FETCH_PC_BP_EN
    bp_exp = 32'h400;
`else
    bp_exp = 32'h48;
`endif
    step();
    check("bp_pc", pc, bp_exp);
    bp_taken = 1'b0;
    bp_target = '0;

    // Sequential wrap at the top of the address space
    redirect(32'hFFFF_FFFC);
    step();
    check("wrap_top_pc", pc, 32'hFFFF_FFFC);
    check("wrap_top_lane", lane_mask, 2'b10);
    no_redirect();
    step();
    check("wrap_pc", pc, 32'h0);
    check("wrap_lane", lane_mask, 2'b11);

    // Asynchronous reset in the middle of HOLD
    Ihit = 1'b0;
    redirect(32'h600);
    step();
    check("hold_pre_rst_pend", redirect_pending, 1'b1);
    no_redirect();
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_pend", redirect_pending, 1'b0);
    Ihit = 1'b1;
    step();
    resetn = 1'b1;
    check("post_rst_pc", pc, 32'h0);
    step();
    check("post_rst_seq1", pc, 32'h8);
    check("post_rst_pend", redirect_pending, 1'b0);
    step();
    check("post_rst_seq2", pc, 32'h10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
